// File: rtl/mem_arbiter.sv
// Arbitrates the single-port data RAM between instruction fetch (read-only) and the LSU.
// LSU wins by default; partial-word stores are executed as a two-cycle read-modify-write.
module mem_arbiter #(
  parameter int AW         = 7,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [3:0]    d_be,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          ram_wren,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  typedef enum logic {ST_IDLE, ST_RMW} state_t;

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_i_rv, r_d_rv;
  logic [AW-1:0] r_addr;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic          w_sel_d, w_rd_i, w_rd_d, w_latch;

  // Fetch wins a tie only once the LSU has been selected STARVE_MAX times in a row.
  assign w_sel_d = d_req && (!i_req || (r_cnt != CNT_MAX));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    i_gnt       = 1'b0;
    d_gnt       = 1'b0;
    ram_wren    = 1'b0;
    ram_addr    = i_addr;
    ram_wdata   = d_wdata;
    w_rd_i      = 1'b0;
    w_rd_d      = 1'b0;
    w_latch     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_sel_d) begin
          ram_addr = d_addr;
          if (!d_we) begin
            d_gnt  = 1'b1;
            w_rd_d = 1'b1;
          end else if (d_be == 4'hF) begin
            d_gnt    = 1'b1;
            ram_wren = 1'b1;
          end else if (d_be == 4'h0) begin
            d_gnt = 1'b1;
          end else begin
            w_latch     = 1'b1;
            w_state_nxt = ST_RMW;
          end
        end else if (i_req) begin
          i_gnt  = 1'b1;
          w_rd_i = 1'b1;
        end
        if (!i_req || i_gnt) w_cnt_nxt = '0;
        else if (w_sel_d && (r_cnt != CNT_MAX)) w_cnt_nxt = r_cnt + 1'b1;
      end
      ST_RMW: begin
        ram_addr = r_addr;
        ram_wren = 1'b1;
        d_gnt    = 1'b1;
        for (int n = 0; n < 4; n++)
          ram_wdata[8*n +: 8] = r_be[n] ? r_wdata[8*n +: 8] : ram_rdata[8*n +: 8];
        w_state_nxt = ST_IDLE;
        if (!i_req) w_cnt_nxt = '0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Reset suppresses every grant and write, which also aborts an RMW in flight.
    if (rst) begin
      i_gnt    = 1'b0;
      d_gnt    = 1'b0;
      ram_wren = 1'b0;
      w_rd_i   = 1'b0;
      w_rd_d   = 1'b0;
      w_latch  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_i_rv  <= 1'b0;
      r_d_rv  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_i_rv  <= w_rd_i;
      r_d_rv  <= w_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_addr  <= d_addr;
      r_be    <= d_be;
      r_wdata <= d_wdata;
    end
  end

  // RAM read data is registered, so it lines up with the rvalid raised one cycle after the grant.
  assign i_rvalid = r_i_rv;
  assign d_rvalid = r_d_rv;
  assign i_rdata  = ram_rdata;
  assign d_rdata  = ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven bench for mem_arbiter: one vector per cycle, plus a read-data scoreboard
// fed from a shadow memory model.
module tb_mem_arbiter;

  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [31:0]   i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [3:0]    d_be;
  logic [31:0]   d_wdata, d_rdata;
  logic          ram_wren;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;

  mem_arbiter #(.AW(AW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_wren(ram_wren), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- RAM model (registered read) ----------------
  logic [31:0] mem [2**AW];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic          rst;
    logic          ir;
    logic [AW-1:0] ia;
    logic          dr;
    logic          dwe;
    logic [AW-1:0] da;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic          eig;
    logic          edg;
    logic          ewr;
    logic          rmw;
    logic [1:0]    asel;  // 0: no address check, 1: i_addr, 2: d_addr
  } vec_t;

  function automatic vec_t mk(input logic r, input logic ir, input logic [AW-1:0] ia,
                              input logic dr, input logic dwe, input logic [AW-1:0] da,
                              input logic [3:0] be, input logic [31:0] wd,
                              input logic eig, input logic edg, input logic ewr,
                              input logic rmw, input logic [1:0] asel);
    vec_t v;
    v.rst = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da; v.be = be;
    v.wd = wd; v.eig = eig; v.edg = edg; v.ewr = ewr; v.rmw = rmw; v.asel = asel;
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [3:0] be,
                                        input logic [31:0] wd);
    logic [31:0] r;
    for (int n = 0; n < 4; n++) r[8*n +: 8] = be[n] ? wd[8*n +: 8] : old_w[8*n +: 8];
    return r;
  endfunction

  function automatic logic [31:0] init_val(input int i);
    return (i == 3) ? 32'h0000_0013 : {8'hA5, 8'(i), 8'(~i), 8'(i * 3)};
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] model_mem [2**AW];
  logic [31:0] exp_iq[$];
  logic [31:0] exp_dq[$];
  logic        exp_iv, exp_dv;
  int          n_chk, n_err, step_no;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h", nm, step_no, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input vec_t v);
    logic [31:0] e, ew;
    rst = v.rst; i_req = v.ir; i_addr = v.ia; d_req = v.dr; d_we = v.dwe;
    d_addr = v.da; d_be = v.be; d_wdata = v.wd;
    @(negedge clk);
    chk("i_gnt", i_gnt, v.eig);
    chk("d_gnt", d_gnt, v.edg);
    chk("ram_wren", ram_wren, v.ewr);
    if (v.asel == 2'd1) chk("ram_addr", ram_addr, v.ia);
    if (v.asel == 2'd2) chk("ram_addr", ram_addr, v.da);
    ew = v.rmw ? merge(model_mem[v.da], v.be, v.wd) : v.wd;
    if (v.ewr) chk("ram_wdata", ram_wdata, ew);
    chk("i_rvalid", i_rvalid, exp_iv);
    chk("d_rvalid", d_rvalid, exp_dv);
    if (exp_iv && exp_iq.size() > 0) begin
      e = exp_iq.pop_front();
      if (i_rvalid) chk("i_rdata", i_rdata, e);
    end
    if (exp_dv && exp_dq.size() > 0) begin
      e = exp_dq.pop_front();
      if (d_rvalid) chk("d_rdata", d_rdata, e);
    end
    exp_iv = v.eig;
    exp_dv = v.edg && !v.dwe;
    if (exp_iv) exp_iq.push_back(model_mem[v.ia]);
    if (exp_dv) exp_dq.push_back(model_mem[v.da]);
    if (v.ewr) model_mem[v.da] = ew;
    step_no++;
    @(posedge clk);
    #1;
  endtask

  // ---------------- test ----------------
  vec_t tbl[$];

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem[i]       = init_val(i);
      model_mem[i] = init_val(i);
    end
    n_chk = 0; n_err = 0; step_no = 0; exp_iv = 1'b0; exp_dv = 1'b0;
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_be = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;

    // reset holds off grants and writes even with both requesters active
    tbl.push_back(mk(1, 1, 7'd3, 1, 1, 7'd5, 4'hF, 32'h1111_1111, 0, 0, 0, 0, 0));
    // fetch only, back-to-back on word 3
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, 1, 7'd3, 0, 0, 7'd0, 4'h0, 32'h0, 1, 0, 0, 0, 1));
    // full store, then load back
    tbl.push_back(mk(0, 0, 7'd0, 1, 1, 7'd5, 4'hF, 32'hDEAD_BEEF, 0, 1, 1, 0, 2));
    tbl.push_back(mk(0, 0, 7'd0, 1, 0, 7'd5, 4'h0, 32'h0, 0, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 7'd0, 0, 0, 7'd0, 4'h0, 32'h0, 0, 0, 0, 0, 0));
    // partial store (lane 1), inputs held through the RMW cycle
    tbl.push_back(mk(0, 0, 7'd0, 1, 1, 7'd5, 4'b0010, 32'h0000_AA00, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 7'd0, 1, 1, 7'd5, 4'b0010, 32'h0000_AA00, 0, 1, 1, 1, 2));
    tbl.push_back(mk(0, 0, 7'd0, 1, 0, 7'd5, 4'h0, 32'h0, 0, 1, 0, 0, 2));
    // empty byte-enable store: granted, nothing written
    tbl.push_back(mk(0, 0, 7'd0, 1, 1, 7'd6, 4'h0, 32'hFFFF_FFFF, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 7'd0, 0, 0, 7'd0, 4'h0, 32'h0, 0, 0, 0, 0, 0));
    // contention: D,D,D,D,I twice
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(0, 1, 7'd3, 1, 0, 7'd5, 4'h0, 32'h0,
                       (k % 5) == 4, (k % 5) != 4, 0, 0, ((k % 5) == 4) ? 2'd1 : 2'd2));
    // partial store racing a fetch: fetch waits out both cycles
    tbl.push_back(mk(0, 1, 7'd3, 1, 1, 7'd7, 4'b0001, 32'h0000_00CC, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 1, 7'd3, 1, 1, 7'd7, 4'b0001, 32'h0000_00CC, 0, 1, 1, 1, 2));
    tbl.push_back(mk(0, 1, 7'd3, 0, 0, 7'd0, 4'h0, 32'h0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 7'd0, 1, 0, 7'd7, 4'h0, 32'h0, 0, 1, 0, 0, 2));
    // random-address streams, one requester at a time
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(0, 1, 7'($urandom_range(127, 0)), 0, 0, 7'd0, 4'h0, 32'h0, 1, 0, 0, 0, 1));
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(0, 0, 7'd0, 1, 0, 7'($urandom_range(127, 0)), 4'h0, 32'h0, 0, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 7'd0, 0, 0, 7'd0, 4'h0, 32'h0, 0, 0, 0, 0, 0));

    foreach (tbl[k]) step(tbl[k]);

    // reset in the RMW cycle: counter built to 4 first, must come back as 0
    for (int k = 0; k < 3; k++)
      step(mk(0, 1, 7'd3, 1, 0, 7'd9, 4'h0, 32'h0, 0, 1, 0, 0, 2));
    step(mk(0, 1, 7'd3, 1, 1, 7'd5, 4'b0100, 32'h0077_0000, 0, 0, 0, 0, 2));
    step(mk(1, 1, 7'd3, 1, 1, 7'd5, 4'b0100, 32'h0077_0000, 0, 0, 0, 0, 0));
    step(mk(0, 1, 7'd3, 1, 0, 7'd5, 4'h0, 32'h0, 0, 1, 0, 0, 2));
    step(mk(0, 0, 7'd0, 0, 0, 7'd0, 4'h0, 32'h0, 0, 0, 0, 0, 0));
    chk("word5_after_abort", model_mem[5], 32'hDEAD_AAEF);
    chk("word5_ram", mem[5], 32'hDEAD_AAEF);
    chk("word7_ram", mem[7], merge(init_val(7), 4'b0001, 32'h0000_00CC));
    chk("i_queue_drained", 32'(exp_iq.size()), 32'd0);
    chk("d_queue_drained", 32'(exp_dq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
